// File: rtl/reg_bank_arbiter.sv
// Two-port round-robin arbiter in front of a small register bank.
// One granted transfer per cycle; each transfer returns a one-cycle response pulse.
module reg_bank_arbiter #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    req0_valid,
    input  logic                    req0_we,
    input  logic [ADDR_W-1:0]       req0_addr,
    input  logic [DATA_W-1:0]       req0_wdata,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic                    req1_we,
    input  logic [ADDR_W-1:0]       req1_addr,
    input  logic [DATA_W-1:0]       req1_wdata,
    output logic                    req1_ready,
    output logic                    rsp0_valid,
    output logic [DATA_W-1:0]       rsp0_rdata,
    output logic                    rsp1_valid,
    output logic [DATA_W-1:0]       rsp1_rdata,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                         ptr_q, ptr_d;
    logic                         rsp0_valid_q, rsp0_valid_d;
    logic                         rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0]            rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0]            rsp1_rdata_q, rsp1_rdata_d;

    logic                         grant0, grant1;
    logic                         sel_we;
    logic [ADDR_W-1:0]            sel_addr;
    logic [DATA_W-1:0]            sel_wdata;
    logic                         in_range;
    logic [DATA_W-1:0]            rd_data;
    logic [DATA_W-1:0]            rsp_data;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant0       = Reset && req0_valid && (!req1_valid || !ptr_q);
        grant1       = Reset && req1_valid && (!req0_valid ||  ptr_q);

        sel_we       = grant1 ? req1_we    : req0_we;
        sel_addr     = grant1 ? req1_addr  : req0_addr;
        sel_wdata    = grant1 ? req1_wdata : req0_wdata;
        in_range     = int'(sel_addr) < NREGS;
        rd_data      = in_range ? regs_q[sel_addr] : '0;
        rsp_data     = sel_we ? sel_wdata : rd_data;

        regs_d       = regs_q;
        ptr_d        = ptr_q;
        rsp0_valid_d = grant0;
        rsp1_valid_d = grant1;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;

        if (grant0 || grant1) begin
            // Favour the loser next time; an idle cycle leaves the pointer alone.
            ptr_d = grant0;
            if (sel_we && in_range) begin
                regs_d[sel_addr] = sel_wdata;
            end
        end
        if (grant0) rsp0_rdata_d = rsp_data;
        if (grant1) rsp1_rdata_d = rsp_data;
    end

    // NOTE: the bank is reset along with the control state because it is architecturally visible on regs_flat.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            regs_q       <= '0;
            ptr_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking so all state updates see the same pre-edge values.
            regs_q       <= regs_d;
            ptr_q        <= ptr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign regs_flat  = regs_q;

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Controller that shares one bank of NREGS 16-bit storage registers between two requesters (port 0, port 1).
- Performs round-robin arbitration, one granted transfer per cycle, and sequences writes and reads into the bank.
- Returns a one-cycle response pulse to the granted port.
- Sits between two datapath masters (e.g. ALU writeback and load unit) and the register storage. The register contents are also exported flat for debug/display.

Parameters:
- DATA_W, 16, width of each stored register and of the data buses.
- NREGS, 4, number of registers in the bank (2..2^ADDR_W).
- ADDR_W, 2, width of the register address.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  port 0 has a transfer pending.
- req0_we  input  1  port 0: 1 = write, 0 = read.
- req0_addr  input  ADDR_W  port 0 register index.
- req0_wdata  input  DATA_W  port 0 write data.
- req0_ready  output  1  port 0 granted this cycle.
- req1_valid, req1_we, req1_addr, req1_wdata  inputs, same meaning for port 1.
- req1_ready  output  1  port 1 granted this cycle.
- rsp0_valid  output  1  one-cycle response pulse for port 0.
- rsp0_rdata  output  DATA_W  port 0 response data.
- rsp1_valid  output  1  one-cycle response pulse for port 1.
- rsp1_rdata  output  DATA_W  port 1 response data.
- regs_flat  output  NREGS*DATA_W  all register contents; reg i at bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (Reset=0, asynchronous):
  - all registers, rsp*_valid and rsp*_rdata go to 0 immediately; priority pointer goes to 0 (port 0 favoured).
  - Pending responses are dropped. req*_ready are forced to 0 while Reset=0.
- Grant logic (combinational from valid inputs and pointer):
  - only req0_valid -> req0_ready=1; only req1_valid -> req1_ready=1.
  - both valid -> grant the port named by the pointer; the other port's ready is 0.
  - never both readys high in the same cycle.
  - A transfer completes at the rising edge where valid&ready=1.
- Pointer: on every completed transfer, pointer <= index of the non-granted port. It holds when idle. This guarantees that a requester held valid waits at most 1 cycle.
- Requester rule: hold valid/we/addr/wdata stable until ready is seen. Dropping valid before grant is allowed (request withdrawn, no response).
- Write (we=1):
  - reg[addr] <= wdata at the completing edge.
  - Next cycle: rsp_valid of that port = 1 for exactly one cycle, and rsp_rdata = wdata (write acknowledge).
- Read (we=0):
  - rsp_rdata <= reg[addr] as sampled at the completing edge.
  - rsp_valid = 1 for one cycle, next cycle. Latency is 1 cycle.
- Back-to-back: a port may transfer every cycle when uncontested. A read granted in the cycle after a write to the same address returns the new value.
- Out-of-range addr (addr >= NREGS, only possible when NREGS < 2^ADDR_W): write is ignored and read returns 0. The response still pulses.
- rsp_rdata holds its last value while rsp_valid=0.
- No backpressure on responses.
- regs_flat reflects the register state directly (registered, no extra latency).

Test Plan:
- Reset: drive Reset=0 mid-transfer with req0 write pending -> all outputs 0 immediately, regs_flat=0, no rsp0_valid after release.
- Single write then read: port 0 write addr 2 = 0xBEEF -> req0_ready same cycle; next cycle rsp0_valid=1, rsp0_rdata=0xBEEF, regs_flat[47:32]=0xBEEF. Port 0 read addr 2 -> rsp0_rdata=0xBEEF one cycle later.
- Contention fairness: both valid continuously, writes addr 0 (port 0 data 0x1111, port 1 data 0x2222) -> grants alternate 0,1,0,1 starting with port 0 after reset. Each port's rsp pulses on alternate cycles.
- Read-after-write across ports: port 1 writes addr 3 = 0x00A5, then port 0 reads addr 3 the next cycle -> rsp0_rdata=0x00A5.
- Pointer hold: port 1 granted alone (pointer -> 0), idle 3 cycles, then both valid -> port 0 granted first.
- Withdrawal: port 1 valid lost arbitration for 1 cycle, then valid dropped -> no rsp1_valid, addressed register unchanged.
